// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: moves up to STEP bit positions per clock,
// with valid/ready handshakes on both the operand and the result side.
module seq_shifter #(
    parameter int DATAWIDTH = 8,
    parameter int SHWIDTH   = 3,
    parameter int STEP      = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [SHWIDTH-1:0]   sh_amt,
    input  logic [2:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] d,
    output logic                 busy
);

    localparam int RW = $clog2(DATAWIDTH + 1);

    localparam logic [2:0] M_SHL  = 3'd0;
    localparam logic [2:0] M_SHR  = 3'd1;
    localparam logic [2:0] M_SRA  = 3'd2;
    localparam logic [2:0] M_ROL  = 3'd3;
    localparam logic [2:0] M_ROR  = 3'd4;
    localparam logic [2:0] M_PASS = 3'd5;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state;
    logic                   loaded;
    logic [DATAWIDTH-1:0]   data;
    logic [RW-1:0]          rem;
    logic [2:0]             mode_r;
    logic [RW-1:0]          k;
    logic [DATAWIDTH-1:0]   next_data;

    // Shifts saturate at DATAWIDTH (all fill bits); rotates wrap modulo DATAWIDTH.
    function automatic logic [RW-1:0] eff_amt(input logic [SHWIDTH-1:0] amt,
                                              input logic [2:0]         m);
        logic [31:0] a32;
        a32 = 32'(amt);
        if (m == M_ROL || m == M_ROR)
            eff_amt = RW'(a32 % 32'(DATAWIDTH));
        else if (a32 > 32'(DATAWIDTH))
            eff_amt = RW'(DATAWIDTH);
        else
            eff_amt = RW'(a32);
    endfunction

    // One partial step of k positions; the arithmetic shift keeps replicating the
    // original sign bit because every step preserves the MSB.
    function automatic logic [DATAWIDTH-1:0] step_op(input logic [DATAWIDTH-1:0] v,
                                                     input logic [RW-1:0]        kk,
                                                     input logic [2:0]           m);
        logic signed [DATAWIDTH-1:0] sv;
        logic [DATAWIDTH-1:0]        res;
        sv  = v;
        res = v;
        case (m)
            M_SHL:   res = v << kk;
            M_SHR:   res = v >> kk;
            M_SRA:   res = sv >>> kk;
            M_ROL:   res = (v << kk) | (v >> (RW'(DATAWIDTH) - kk));
            M_ROR:   res = (v >> kk) | (v << (RW'(DATAWIDTH) - kk));
            default: res = v;
        endcase
        step_op = res;
    endfunction

    always_comb begin
        k         = (rem > RW'(STEP)) ? RW'(STEP) : rem;
        next_data = step_op(data, k, mode_r);
    end

    // The effective amount is registered at accept so the modulo stays off the
    // decision path; the following cycle chooses between SHIFT and DONE.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            loaded    <= 1'b0;
            data      <= '0;
            rem       <= '0;
            mode_r    <= '0;
            d         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (loaded) begin
                        loaded <= 1'b0;
                        busy   <= 1'b1;
                        if (rem == '0 || mode_r >= M_PASS) begin
                            d         <= data;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
                    end else if (in_valid) begin
                        data     <= a;
                        mode_r   <= mode;
                        rem      <= eff_amt(sh_amt, mode);
                        loaded   <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                SHIFT: begin
                    data <= next_data;
                    rem  <= rem - k;
                    if (rem == k) begin
                        d         <= next_data;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    loaded    <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: one STEP=1 and one STEP=3 instance share the
// same stimulus; results and per-instance latencies are checked against hand values.
module tb_seq_shifter;

    localparam logic [2:0] SHL = 3'd0;
    localparam logic [2:0] SHR = 3'd1;
    localparam logic [2:0] SRA = 3'd2;
    localparam logic [2:0] ROL = 3'd3;
    localparam logic [2:0] ROR = 3'd4;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = 8'h00;
    logic [3:0] sh_amt = 4'd0;
    logic [2:0] mode = 3'd0;

    logic       in_ready1, out_valid1, busy1;
    logic       in_ready3, out_valid3, busy3;
    logic [7:0] d1, d3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    seq_shifter #(.DATAWIDTH(8), .SHWIDTH(4), .STEP(1)) u_s1 (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .sh_amt(sh_amt), .mode(mode), .out_valid(out_valid1),
        .out_ready(out_ready), .d(d1), .busy(busy1)
    );

    seq_shifter #(.DATAWIDTH(8), .SHWIDTH(4), .STEP(3)) u_s3 (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready3),
        .a(a), .sh_amt(sh_amt), .mode(mode), .out_valid(out_valid3),
        .out_ready(out_ready), .d(d3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic release_out(input string tag, input logic [7:0] exp_d);
        @(negedge Clk);
        out_ready = 1'b1;
        @(posedge Clk);
        #1 out_ready = 1'b0;
        chk({tag, "/ovld1_off"}, 32'(out_valid1), 0);
        chk({tag, "/ovld3_off"}, 32'(out_valid3), 0);
        chk({tag, "/rdy1_back"}, 32'(in_ready1), 1);
        chk({tag, "/rdy3_back"}, 32'(in_ready3), 1);
        chk({tag, "/busy1_off"}, 32'(busy1), 0);
        chk({tag, "/d1_kept"}, 32'(d1), 32'(exp_d));
    endtask

    task automatic run_op(input string tag, input logic [2:0] m, input logic [7:0] av,
                          input logic [3:0] amt, input logic [7:0] exp_d,
                          input int lat1, input int lat3, input bit release_it);
        int seen1, seen3;
        bit ir_bad;
        @(negedge Clk);
        chk({tag, "/rdy1"}, 32'(in_ready1), 1);
        chk({tag, "/rdy3"}, 32'(in_ready3), 1);
        mode = m; a = av; sh_amt = amt; in_valid = 1'b1;
        @(posedge Clk);
        #1 in_valid = 1'b0;
        seen1 = 0; seen3 = 0; ir_bad = 1'b0;
        for (int n = 1; n <= 40 && (seen1 == 0 || seen3 == 0); n++) begin
            if (!out_valid1 && in_ready1) ir_bad = 1'b1;
            if (!out_valid3 && in_ready3) ir_bad = 1'b1;
            @(posedge Clk);
            #1;
            if (seen1 == 0 && out_valid1) seen1 = n;
            if (seen3 == 0 && out_valid3) seen3 = n;
        end
        chk({tag, "/lat1"}, 32'(seen1), 32'(lat1));
        chk({tag, "/lat3"}, 32'(seen3), 32'(lat3));
        chk({tag, "/d1"}, 32'(d1), 32'(exp_d));
        chk({tag, "/d3"}, 32'(d3), 32'(exp_d));
        chk({tag, "/rdy_low_while_busy"}, 32'(ir_bad), 0);
        chk({tag, "/busy1"}, 32'(busy1), 1);
        if (release_it) release_out(tag, exp_d);
    endtask

    initial begin
        #1 Rst = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst/rdy1", 32'(in_ready1), 1);
        chk("rst/rdy3", 32'(in_ready3), 1);
        chk("rst/ovld1", 32'(out_valid1), 0);
        chk("rst/busy1", 32'(busy1), 0);
        chk("rst/d1", 32'(d1), 0);
        chk("rst/d3", 32'(d3), 0);
        @(negedge Clk);
        Rst = 1'b1;

        run_op("shl03",   SHL,  8'h03, 4'd2,  8'h0C, 3, 2, 1'b1);
        run_op("shr90",   SHR,  8'h90, 4'd3,  8'h12, 4, 2, 1'b1);
        run_op("sra90",   SRA,  8'h90, 4'd3,  8'hF2, 4, 2, 1'b1);
        run_op("shlff7",  SHL,  8'hFF, 4'd7,  8'h80, 8, 4, 1'b1);
        run_op("rol81",   ROL,  8'h81, 4'd9,  8'h03, 2, 2, 1'b1);
        run_op("shlff12", SHL,  8'hFF, 4'd12, 8'h00, 9, 4, 1'b1);
        run_op("amt0",    SHL,  8'h5A, 4'd0,  8'h5A, 1, 1, 1'b1);
        run_op("mode6",   3'd6, 8'h5A, 4'd5,  8'h5A, 1, 1, 1'b1);
        run_op("mode7",   3'd7, 8'hC3, 4'd15, 8'hC3, 1, 1, 1'b1);
        run_op("ror96",   ROR,  8'h96, 4'd11, 8'hD2, 4, 2, 1'b1);
        run_op("rolb1",   ROL,  8'hB1, 4'd4,  8'h1B, 5, 3, 1'b1);
        run_op("sra80",   SRA,  8'h80, 4'd15, 8'hFF, 9, 4, 1'b1);
        run_op("sra70",   SRA,  8'h70, 4'd12, 8'h00, 9, 4, 1'b1);
        run_op("shrff5",  SHR,  8'hFF, 4'd5,  8'h07, 6, 3, 1'b1);
        run_op("rol8",    ROL,  8'h5A, 4'd8,  8'h5A, 1, 1, 1'b1);

        // Result must sit untouched in DONE while in_valid toggles.
        run_op("hold", SHL, 8'h03, 4'd1, 8'h06, 2, 2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            in_valid = ~in_valid; a = 8'hFF; mode = SHL; sh_amt = 4'd1;
            @(posedge Clk);
            #1;
            chk("hold/ovld1", 32'(out_valid1), 1);
            chk("hold/ovld3", 32'(out_valid3), 1);
            chk("hold/d1", 32'(d1), 32'h06);
            chk("hold/d3", 32'(d3), 32'h06);
            chk("hold/rdy1", 32'(in_ready1), 0);
        end
        @(negedge Clk);
        in_valid = 1'b0;
        release_out("hold", 8'h06);
        repeat (3) @(posedge Clk);
        #1;
        chk("hold/no_ghost_ovld", 32'(out_valid1), 0);
        chk("hold/no_ghost_rdy", 32'(in_ready1), 1);

        // Abort mid-SHIFT with the asynchronous reset.
        @(negedge Clk);
        mode = SHL; a = 8'hFF; sh_amt = 4'd8; in_valid = 1'b1;
        @(posedge Clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("abort/busy1_pre", 32'(busy1), 1);
        chk("abort/busy3_pre", 32'(busy3), 1);
        Rst = 1'b0;
        #1;
        chk("abort/ovld1", 32'(out_valid1), 0);
        chk("abort/d1", 32'(d1), 0);
        chk("abort/d3", 32'(d3), 0);
        chk("abort/rdy1", 32'(in_ready1), 1);
        chk("abort/rdy3", 32'(in_ready3), 1);
        chk("abort/busy1", 32'(busy1), 0);
        @(negedge Clk);
        Rst = 1'b1;
        run_op("ror01", ROR, 8'h01, 4'd1, 8'h80, 2, 2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
